// File: rtl/bsg_adder_carry_save_resolver.sv
// Resolves a carry-save pair into one binary sum, one chunk per cycle.
// Chunk 0 is added in the accept cycle; later chunks use the latched pair.
module bsg_adder_carry_save_resolver #(
  parameter int width_p = 32,
  parameter int chunk_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] resA_i,
  input  logic [width_p-1:0] resB_i,
  output logic               v_o,
  output logic [width_p-1:0] sum_o,
  output logic               carry_o,
  input  logic               yumi_i
);

  localparam int num_chunks_lp = width_p / chunk_p;
  localparam int cnt_w_lp =
    (num_chunks_lp > 1) ? $clog2(num_chunks_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_lp =
    cnt_w_lp'(num_chunks_lp - 1);

  if ((chunk_p < 1) || (chunk_p > width_p)
      || ((width_p % chunk_p) != 0)) begin : g_bad_param
    $error("bad width_p/chunk_p combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef logic [num_chunks_lp-1:0][chunk_p-1:0] vec_t;

  state_e              state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  vec_t                a_q, a_d;
  vec_t                b_q, b_d;
  vec_t                sum_q, sum_d;

  vec_t                a_src, b_src;
  logic [cnt_w_lp-1:0] k;
  logic                c_in;
  logic                step;
  logic [chunk_p:0]    add;

  // Next-state, chunk selection and the single chunk adder.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    a_src   = a_q;
    b_src   = b_q;
    k       = cnt_q;
    c_in    = carry_q;
    step    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (v_i) begin
          a_src = resA_i;
          b_src = resB_i;
          a_d   = resA_i;
          b_d   = resB_i;
          k     = '0;
          c_in  = 1'b0;
          step  = 1'b1;
        end
      end
      BUSY: step = 1'b1;
      DONE: begin
        if (yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    add = {1'b0, a_src[k]}
        + {1'b0, b_src[k]}
        + {{chunk_p{1'b0}}, c_in};

    if (step) begin
      sum_d[k] = add[chunk_p-1:0];
      carry_d  = add[chunk_p];
      if (k == last_lp) begin
        state_d = DONE;
        cout_d  = add[chunk_p];
        cnt_d   = '0;
      end else begin
        state_d = BUSY;
        cnt_d   = k + cnt_w_lp'(1);
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign ready_o = (state_q == IDLE) & ~reset_i;
  assign v_o     = (state_q == DONE);
  assign sum_o   = sum_q;
  assign carry_o = cout_q;

`ifndef SYNTHESIS
  // A consumer taking a result that is not offered is a protocol error.
  always_ff @(posedge clk_i) begin
    if (!reset_i && yumi_i && !v_o)
      $error("yumi_i asserted while v_o=0");
  end
`endif

endmodule

// File: tb/tb_bsg_adder_carry_save_resolver.sv
// Bench for the carry-save resolver.
// Two instances: 32/8 chunked and 16/16 single-cycle.
module tb_bsg_adder_carry_save_resolver;

  logic clk = 1'b0;
  logic rst;

  logic        v0, r0, vo0, c0, y0;
  logic [31:0] a0, b0, s0;
  logic        v1, r1, vo1, c1, y1;
  logic [15:0] a1, b1, s1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bsg_adder_carry_save_resolver #(
    .width_p(32),
    .chunk_p(8)
  ) u0 (
    .clk_i  (clk),
    .reset_i(rst),
    .v_i    (v0),
    .ready_o(r0),
    .resA_i (a0),
    .resB_i (b0),
    .v_o    (vo0),
    .sum_o  (s0),
    .carry_o(c0),
    .yumi_i (y0)
  );

  bsg_adder_carry_save_resolver #(
    .width_p(16),
    .chunk_p(16)
  ) u1 (
    .clk_i  (clk),
    .reset_i(rst),
    .v_i    (v1),
    .ready_o(r1),
    .resA_i (a1),
    .resB_i (b1),
    .v_o    (vo1),
    .sum_o  (s1),
    .carry_o(c1),
    .yumi_i (y1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One transaction on the 32/8 instance; called at a negedge in IDLE.
  task automatic run0(input logic [31:0] a,
                      input logic [31:0] b,
                      input int hold);
    logic [32:0] exp;
    int k;
    exp = {1'b0, a} + {1'b0, b};
    chk("ready_pre", r0, 1);
    v0 = 1'b1;
    a0 = a;
    b0 = b;
    k = 0;
    do begin
      @(negedge clk);
      v0 = 1'b0;
      a0 = $urandom;
      b0 = $urandom;
      k++;
      if (!vo0) chk("ready_busy", r0, 0);
    end while (!vo0 && k < 20);
    chk("latency", k, 4);
    chk("sum", {c0, s0}, exp);
    repeat (hold) begin
      chk("ready_hold", r0, 0);
      @(negedge clk);
      chk("hold", {vo0, c0, s0}, {1'b1, exp});
    end
    chk("ready_done", r0, 0);
    y0 = 1'b1;
    @(negedge clk);
    y0 = 1'b0;
    chk("yumi_v", vo0, 0);
    chk("yumi_rdy", r0, 1);
  endtask

  // One transaction on the 16/16 instance; result expected next cycle.
  task automatic run1(input logic [15:0] a,
                      input logic [15:0] b);
    logic [16:0] exp;
    exp = {1'b0, a} + {1'b0, b};
    chk("r1_ready", r1, 1);
    v1 = 1'b1;
    a1 = a;
    b1 = b;
    @(negedge clk);
    v1 = 1'b0;
    a1 = 16'($urandom);
    b1 = 16'($urandom);
    chk("r1_v", vo1, 1);
    chk("r1_sum", {c1, s1}, exp);
    y1 = 1'b1;
    @(negedge clk);
    y1 = 1'b0;
    chk("r1_after", {vo1, r1}, 2'b01);
  endtask

  initial begin
    logic [32:0] q[$];
    int acc;
    int n_out;
    int cyc;

    rst = 1'b1;
    v0 = 1'b0; y0 = 1'b0; a0 = '0; b0 = '0;
    v1 = 1'b0; y1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy0", r0, 0);
    chk("rst_v0", vo0, 0);
    chk("rst_sum0", {c0, s0}, 0);
    chk("rst_rdy1", r1, 0);
    chk("rst_v1", vo1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy0", r0, 1);
    chk("idle_v0", vo0, 0);
    chk("idle_sum0", {c0, s0}, 0);
    chk("idle_rdy1", r1, 1);

    run0(32'hFFFF_FFFF, 32'h0000_0001, 0);
    run0(32'h1234_5678, 32'h0F0F_0F0F, 10);
    for (int i = 0; i < 8; i++) run0($urandom, $urandom, i % 3);

    // Reset while the third chunk is being added.
    v0 = 1'b1;
    a0 = $urandom;
    b0 = $urandom;
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_v", vo0, 0);
    chk("mid_rst_rdy", r0, 0);
    chk("mid_rst_sum", {c0, s0}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", r0, 1);
    chk("post_rst_v", vo0, 0);
    run0(32'd3, 32'd4, 1);

    run1(16'h8000, 16'h8000);
    for (int i = 0; i < 20; i++) run1(16'($urandom), 16'($urandom));

    // Random stream with stalls on both sides.
    acc = 0;
    n_out = 0;
    cyc = 0;
    while ((acc < 1000 || q.size() != 0) && cyc < 60000) begin
      chk("s_rdy", r0, q.size() == 0);
      y0 = 1'b0;
      if (vo0) begin
        if (q.size() == 0) begin
          chk("s_extra", vo0, 0);
        end else begin
          chk("s_sum", {c0, s0}, q[0]);
          if ($urandom_range(1, 0) == 1) begin
            y0 = 1'b1;
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      v0 = (acc < 1000) && ($urandom_range(1, 0) == 1);
      a0 = $urandom;
      b0 = $urandom;
      if (v0 && r0) begin
        q.push_back({1'b0, a0} + {1'b0, b0});
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    v0 = 1'b0;
    y0 = 1'b0;
    chk("s_accepted", acc, 1000);
    chk("s_returned", n_out, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
